// File: rtl/branch_pkg.sv
// Shared BrOp encodings for the branch unit.
// BR_JUMP / BR_NONE are wildcard prefixes ('?' bits) meant for casez decode.
package branch_pkg;

  localparam int BROP_W = 5;

  localparam logic [BROP_W-1:0] BR_JUMP = 5'b1????;
  localparam logic [BROP_W-1:0] BR_NONE = 5'b00???;
  localparam logic [BROP_W-1:0] BEQ     = 5'b01000;
  localparam logic [BROP_W-1:0] BNE     = 5'b01001;
  localparam logic [BROP_W-1:0] BLT     = 5'b01100;
  localparam logic [BROP_W-1:0] BGE     = 5'b01101;
  localparam logic [BROP_W-1:0] BLTU    = 5'b01110;
  localparam logic [BROP_W-1:0] BGEU    = 5'b01111;

  // True only for the six conditional compare codes; 01010/01011 are unused.
  function automatic logic br_is_cond(input logic [BROP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      BEQ, BNE, BLT, BGE, BLTU, BGEU: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator for the branch unit.
// Ports:
//   i_rs1, i_rs2    : XLEN-bit operands
//   o_eq            : i_rs1 == i_rs2
//   o_lt_signed     : i_rs1 <  i_rs2, two's complement
//   o_lt_unsigned   : i_rs1 <  i_rs2, unsigned
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_eq,
  output logic            o_lt_signed,
  output logic            o_lt_unsigned
);

  assign o_eq          = (i_rs1 == i_rs2);
  assign o_lt_signed   = ($signed(i_rs1) < $signed(i_rs2));
  assign o_lt_unsigned = (i_rs1 < i_rs2);

endmodule

// File: rtl/branch_unit.sv
// Branch decision unit: decides PC+4 vs branch target from BrOp and operands.
// Optional statistics counters are built when BRANCH_UNIT_STATS_EN is defined.
// Ports:
//   clk, rst            : clock and async active-high reset (counters only)
//   rs1, rs2            : XLEN-bit compare operands
//   BrOp                : 5-bit branch operation
//   NextPcSrc           : 1 = branch target, 0 = PC+4 (combinational)
//   cnt_clr             : sync clear of counters          (stats build only)
//   br_cnt, taken_cnt   : conditional / taken counters    (stats build only)
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [BROP_W-1:0]   BrOp,
  output logic                NextPcSrc
`ifdef BRANCH_UNIT_STATS_EN
  ,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    br_cnt,
  output logic [CNT_W-1:0]    taken_cnt
`endif
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;
  logic w_next;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .o_eq          (w_eq),
    .o_lt_signed   (w_lt_s),
    .o_lt_unsigned (w_lt_u)
  );

  // Unmatched or X/Z codes fall through to the default of 0.
  always_comb begin
    w_next = 1'b0;
    casez (BrOp)
      BR_JUMP: w_next = 1'b1;
      BR_NONE: w_next = 1'b0;
      BEQ:     w_next = w_eq;
      BNE:     w_next = ~w_eq;
      BLT:     w_next = w_lt_s;
      BGE:     w_next = ~w_lt_s;
      BLTU:    w_next = w_lt_u;
      BGEU:    w_next = ~w_lt_u;
      default: w_next = 1'b0;
    endcase
  end

  assign NextPcSrc = w_next;

`ifdef BRANCH_UNIT_STATS_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             w_is_cond;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign w_is_cond = br_is_cond(BrOp);

  // Counters wrap naturally; clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (cnt_clr) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_is_cond) r_br_cnt    <= r_br_cnt + CNT_ONE;
      if (w_next)    r_taken_cnt <= r_taken_cnt + CNT_ONE;
    end
  end

  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;
`else
  // Purely combinational build: clock, reset and counter width are unused.
  localparam int unused_cnt_w = CNT_W;
  logic w_unused;
  assign w_unused = ^{clk, rst};
`endif

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      BrOp;
  logic            NextPcSrc;
`ifdef BRANCH_UNIT_STATS_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
`endif

  int n_vec;
  int n_err;
  int mdl_br;
  int mdl_tk;

  branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1       (rs1),
    .rs2       (rs2),
    .BrOp      (BrOp),
    .NextPcSrc (NextPcSrc)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .cnt_clr   (cnt_clr),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straight from the opcode table, using plain integer compares.
  function automatic logic ref_take(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    int    sa, sb;
    longint ua, ub;
    sa = a;
    sb = b;
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op >= 5'd16) return 1'b1;
    case (op)
      5'b01000: return a == b;
      5'b01001: return a != b;
      5'b01100: return sa < sb;
      5'b01101: return sa >= sb;
      5'b01110: return ua < ub;
      5'b01111: return ua >= ub;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [4:0] op);
    return op inside {5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15};
  endfunction

  // One cycle: drive at negedge, check the combinational output, then let a
  // rising edge happen and check the counters against the model.
  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic clr, input string tag);
    logic exp;
    @(negedge clk);
    BrOp = op;
    rs1  = a;
    rs2  = b;
`ifdef BRANCH_UNIT_STATS_EN
    cnt_clr = clr;
`endif
    #1;
    exp = ref_take(a, b, op);
    n_vec++;
    if (NextPcSrc !== exp) begin
      n_err++;
      $display("FAIL %s op=%b rs1=%h rs2=%h NextPcSrc=%b want %b", tag, op, a, b, NextPcSrc, exp);
    end
    @(posedge clk);
    if (clr) begin
      mdl_br = 0;
      mdl_tk = 0;
    end else begin
      if (ref_cond(op)) mdl_br = (mdl_br + 1) % (1 << CNT_W);
      if (exp)          mdl_tk = (mdl_tk + 1) % (1 << CNT_W);
    end
`ifdef BRANCH_UNIT_STATS_EN
    #1;
    n_vec++;
    if (br_cnt !== CNT_W'(mdl_br) || taken_cnt !== CNT_W'(mdl_tk)) begin
      n_err++;
      $display("FAIL %s_cnt br_cnt=%0d taken_cnt=%0d want %0d %0d", tag, br_cnt, taken_cnt, mdl_br, mdl_tk);
    end
    cnt_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rs1  = 32'd1;
    rs2  = 32'd1;
    BrOp = 5'b10000;
    #3;
    n_vec++;
    if (NextPcSrc !== 1'b1) begin
      n_err++;
      $display("FAIL reset_passthru NextPcSrc=%b want 1", NextPcSrc);
    end
`ifdef BRANCH_UNIT_STATS_EN
    n_vec++;
    if (br_cnt !== '0 || taken_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_cnt br_cnt=%0d taken_cnt=%0d want 0 0", br_cnt, taken_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    mdl_br = 0;
    mdl_tk = 0;
  endtask

  task automatic test_directed();
    step(5'b10000, 32'd1, 32'd1, 1'b0, "jump");
    step(5'b00000, 32'd1, 32'd0, 1'b0, "none");
    step(5'b01000, 32'h10, 32'h10, 1'b0, "beq_eq");
    step(5'b01001, 32'd1, 32'd1, 1'b0, "bne_eq");
    step(5'b01001, 32'd1, 32'd2, 1'b0, "bne_ne");
    step(5'b01100, 32'hF0000003, 32'd2, 1'b0, "blt_neg");
    step(5'b01110, 32'hF0000003, 32'd2, 1'b0, "bltu_big");
    step(5'b01101, 32'd2, 32'd4, 1'b0, "bge_lt");
    step(5'b01111, 32'd2, 32'd1, 1'b0, "bgeu_gt");
    step(5'b01111, 32'd7, 32'd7, 1'b0, "bgeu_eq");
    step(5'b01010, 32'd5, 32'd5, 1'b0, "unused_a");
    step(5'b01011, 32'd5, 32'd6, 1'b0, "unused_b");
    step(5'b11111, 32'd0, 32'hFFFFFFFF, 1'b0, "jump_max");
    step(5'b01100, 32'h7FFFFFFF, 32'h80000000, 1'b0, "blt_edge");
    step(5'b01110, 32'h7FFFFFFF, 32'h80000000, 1'b0, "bltu_edge");
  endtask

  task automatic test_stats_seq();
    step(5'b00000, 32'd0, 32'd0, 1'b1, "pre_clr");
    step(5'b01000, 32'd3, 32'd3, 1'b0, "st_beq");
    step(5'b01001, 32'd3, 32'd3, 1'b0, "st_bne");
    step(5'b10000, 32'd0, 32'd0, 1'b0, "st_jump");
    step(5'b00000, 32'd0, 32'd0, 1'b0, "st_none");
    n_vec++;
    if (mdl_br != 2 || mdl_tk != 2) begin
      n_err++;
      $display("FAIL stats_model br=%0d tk=%0d want 2 2", mdl_br, mdl_tk);
    end
    step(5'b01000, 32'd9, 32'd9, 1'b1, "clr_prio");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [4:0]  op;
    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = a + 32'd1;
        2: b = a - 32'd1;
        3: b = a ^ 32'h80000000;
        default: b = $urandom;
      endcase
      step(op, a, b, ($urandom_range(0, 40) == 0), "rand");
    end
  endtask

  task automatic test_async_reset();
    step(5'b10000, 32'd0, 32'd0, 1'b0, "ar_pre1");
    step(5'b01000, 32'd4, 32'd4, 1'b0, "ar_pre2");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
`ifdef BRANCH_UNIT_STATS_EN
    n_vec++;
    if (br_cnt !== '0 || taken_cnt !== '0) begin
      n_err++;
      $display("FAIL async_rst br_cnt=%0d taken_cnt=%0d want 0 0", br_cnt, taken_cnt);
    end
`endif
    n_vec++;
    if (NextPcSrc !== ref_take(rs1, rs2, BrOp)) begin
      n_err++;
      $display("FAIL rst_no_gate NextPcSrc=%b want %b", NextPcSrc, ref_take(rs1, rs2, BrOp));
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_br = 0;
    mdl_tk = 0;
    step(5'b01101, 32'd5, 32'd1, 1'b0, "post_rst");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mdl_br = 0;
    mdl_tk = 0;
`ifdef BRANCH_UNIT_STATS_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_stats_seq();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
- REQ-001: Parameter XLEN, default 32: operand width.
- REQ-002: Parameter CNT_W, default 32: statistics counter width.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: rs1  input  XLEN  first comparison operand (register rs1 value).
- REQ-006: rs2  input  XLEN  second comparison operand (register rs2 value).
- REQ-007: BrOp  input  5  branch operation code.
- REQ-008: NextPcSrc  output  1  1 = take branch target, 0 = PC+4.
- REQ-009: cnt_clr  input  1  synchronous clear of statistics counters (present only with BRANCH_UNIT_STATS_EN).
- REQ-010: br_cnt  output  CNT_W  number of conditional branches evaluated (present only with BRANCH_UNIT_STATS_EN).
- REQ-011: taken_cnt  output  CNT_W  number of branches taken, conditional and unconditional (present only with BRANCH_UNIT_STATS_EN).

Function
- REQ-012: NextPcSrc SHALL be purely combinational from rs1, rs2 and BrOp, with zero-cycle latency; clk and rst SHALL NOT affect it.
- REQ-013: BrOp = 1xxxx (jump): NextPcSrc = 1 regardless of operands.
- REQ-014: BrOp = 00xxx (no branch): NextPcSrc = 0.
- REQ-015: BrOp = 01000 (BEQ): NextPcSrc = (rs1 == rs2).
- REQ-016: BrOp = 01001 (BNE): NextPcSrc = (rs1 != rs2).
- REQ-017: BrOp = 01100 (BLT): NextPcSrc = signed rs1 < signed rs2, two's complement over the full XLEN.
- REQ-018: BrOp = 01101 (BGE): NextPcSrc = signed rs1 >= signed rs2.
- REQ-019: BrOp = 01110 (BLTU): NextPcSrc = unsigned rs1 < unsigned rs2.
- REQ-020: BrOp = 01111 (BGEU): NextPcSrc = unsigned rs1 >= unsigned rs2.
- REQ-021: BrOp = 01010 or 01011 (unused): NextPcSrc = 0; these SHALL NOT count as evaluated branches.
- REQ-022: X/Z on BrOp: no latch inferred; default decode path yields 0.

Reset
- REQ-023: While rst = 1, br_cnt and taken_cnt SHALL be 0 immediately, independent of clk.
- REQ-024: Reset SHALL NOT gate or alter NextPcSrc.

Configuration
- REQ-025: Macro BRANCH_UNIT_STATS_EN defined: cnt_clr, br_cnt and taken_cnt SHALL exist with the behaviour in REQ-026..REQ-028.
- REQ-026: Each rising clk edge: br_cnt increments when BrOp is one of the six valid conditional codes; taken_cnt increments when NextPcSrc = 1.
- REQ-027: Both counters SHALL wrap modulo 2^CNT_W, and neither SHALL saturate.
- REQ-028: cnt_clr = 1 on an edge SHALL load 0 and take priority over a simultaneous increment.
- REQ-029: Macro undefined: the ports and state listed in REQ-025 SHALL be absent, and the block SHALL be purely combinational apart from the unused clk and rst.

Structure
- REQ-030: Shared package branch_pkg SHALL hold the BrOp encodings as named constants: BR_JUMP prefix, BR_NONE prefix, BEQ, BNE, BLT, BGE, BLTU, BGEU.
- REQ-031: One sub-module, branch_cmp, SHALL compute eq, lt_signed and lt_unsigned from rs1 and rs2; branch_unit SHALL decode BrOp over those results.

Verification
- REQ-032: Jump: rs1=1, rs2=1, BrOp=10000 -> NextPcSrc=1. None: rs1=1, rs2=0, BrOp=00000 -> 0.
- REQ-033: Equality: BEQ rs1=rs2=0x10 -> 1. BNE rs1=rs2=1 -> 0. BNE rs1=1, rs2=2 -> 1.
- REQ-034: Signed vs unsigned: rs1=0xF0000003, rs2=2; BLT -> 1; BLTU -> 0.
- REQ-035: Greater-or-equal: BGE rs1=2, rs2=4 -> 0. BGEU rs1=2, rs2=1 -> 1. BGEU rs1=rs2 -> 1. Unused code BrOp=01010 -> 0.
- REQ-036: Statistics (macro defined): reset, then apply BEQ-taken, BNE-not-taken, jump and none on 4 edges -> br_cnt=2, taken_cnt=2. Then cnt_clr together with a taken branch -> both 0.
- REQ-037: Async reset: assert rst mid-cycle with counters nonzero -> counters read 0 before the next clk edge.
